// File: rtl/mailbox_poller_if.sv
// Bus bundle for mailbox_poller: Avalon-MM read port toward the mailbox
// and the valid/ready word stream toward the consumer.
interface mailbox_poller_if;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_slot;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_slot
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_slot
  );
endinterface

// File: rtl/mailbox_poller.sv
// Round-robin scanner of mailbox fresh flags; each fresh slot's word is read
// (clearing the flag) and presented on a valid/ready stream tagged with its slot.
module mailbox_poller #(
  parameter int NUM_SLOTS = 4,
  parameter int POLL_GAP  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  mailbox_poller_if.master bus,
  output logic [15:0]      words_count
);

  typedef enum logic [1:0] {
    ST_GAP   = 2'd0,
    ST_POLL  = 2'd1,
    ST_FETCH = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam logic [3:0]  LAST_SLOT = 4'(NUM_SLOTS - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(POLL_GAP);

  state_t      state_q, state_d;
  logic [15:0] gap_q, gap_d;
  logic [3:0]  slot_q, slot_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  oslot_q, oslot_d;
  logic [15:0] count_q, count_d;

  state_t      adv_state;
  logic [3:0]  adv_slot;
  logic [15:0] adv_gap;

  // Moving past a slot, whether it was empty or just delivered.
  always_comb begin
    adv_state = ST_POLL;
    adv_slot  = slot_q + 4'd1;
    adv_gap   = gap_q;
    if (slot_q == LAST_SLOT) begin
      adv_slot  = 4'd0;
      adv_state = ST_GAP;
      adv_gap   = GAP_LOAD;
    end else if (!enable) begin
      adv_state = ST_GAP;
      adv_gap   = GAP_LOAD;
    end
  end

  always_comb begin
    state_d         = state_q;
    gap_d           = gap_q;
    slot_d          = slot_q;
    data_d          = data_q;
    oslot_d         = oslot_q;
    count_d         = count_q;
    bus.avm_read    = 1'b0;
    bus.avm_address = 5'd0;
    bus.out_valid   = 1'b0;

    unique case (state_q)
      ST_GAP: begin
        // The counter holds the idle cycles still owed, this one included.
        gap_d = (gap_q == 16'd0) ? 16'd0 : gap_q - 16'd1;
        if ((gap_q <= 16'd1) && enable) begin
          state_d = ST_POLL;
        end
      end

      ST_POLL: begin
        bus.avm_read    = 1'b1;
        bus.avm_address = {1'b1, slot_q};
        if (bus.avm_readdata[0]) begin
          state_d = ST_FETCH;
        end else begin
          state_d = adv_state;
          slot_d  = adv_slot;
          gap_d   = adv_gap;
        end
      end

      ST_FETCH: begin
        bus.avm_read    = 1'b1;
        bus.avm_address = {1'b0, slot_q};
        data_d          = bus.avm_readdata;
        oslot_d         = slot_q;
        state_d         = ST_OUT;
      end

      ST_OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          count_d = count_q + 16'd1;
          state_d = adv_state;
          slot_d  = adv_slot;
          gap_d   = adv_gap;
        end
      end

      default: begin
        state_d = ST_GAP;
        gap_d   = GAP_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_GAP;
      gap_q   <= GAP_LOAD;
      slot_q  <= 4'd0;
      data_q  <= 32'd0;
      oslot_q <= 4'd0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      slot_q  <= slot_d;
      data_q  <= data_d;
      oslot_q <= oslot_d;
      count_q <= count_d;
    end
  end

  assign bus.out_data = data_q;
  assign bus.out_slot = oslot_q;
  assign words_count  = count_q;

endmodule
